// File: rtl/shift_pkg.sv
// Shared constants for the two-port packet arbiter in front of the shift datapath.
package shift_pkg;

    localparam int DATA_W = 256;
    localparam int CNT_W  = 16;
    localparam int BEAT_W = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// One valid/ready stream with tlast; the arbiter sees its inputs as slaves and its output as master.
interface shift_arbiter_if #(
    parameter int DATA_W = shift_pkg::DATA_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/shift_arbiter_rr_pick2.sv
// Two-way round-robin choice: a lone requester wins, a tie goes to the port not granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);
    always_comb begin
        winner = req[1];
        if (&req) winner = ~last_grant;
    end
endmodule

// File: rtl/shift_arbiter.sv
// Packet-granular two-port arbiter feeding the shift datapath; data passes through with zero latency.
module shift_arbiter
    import shift_pkg::ST_IDLE, shift_pkg::ST_GRANT0, shift_pkg::ST_GRANT1, shift_pkg::sat_inc;
#(
    parameter int DATA_W = shift_pkg::DATA_W,
    parameter int CNT_W  = shift_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    shift_arbiter_if.slave   s0,
    shift_arbiter_if.slave   s1,
    shift_arbiter_if.master  m,
    output logic             grant_id,
    output logic             busy,
    output logic [5:0]       beat_cnt,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [5:0]       beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
    logic [DATA_W-1:0] data_sel;
    logic             winner;
    logic             accept;

    rr_pick2 u_pick (
        .req        ({s1.tvalid, s0.tvalid}),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        data_sel  = '0;
        m.tvalid  = 1'b0;
        m.tlast   = 1'b0;
        s0.tready = 1'b0;
        s1.tready = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                data_sel  = s0.tdata;
                m.tvalid  = s0.tvalid;
                m.tlast   = s0.tlast;
                s0.tready = m.tready;
            end
            ST_GRANT1: begin
                data_sel  = s1.tdata;
                m.tvalid  = s1.tvalid;
                m.tlast   = s1.tlast;
                s1.tready = m.tready;
            end
            default: ;
        endcase
        m.tdata = data_sel;
    end

    assign accept = m.tvalid && m.tready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_cnt0_d   = pkt_cnt0_q;
        pkt_cnt1_d   = pkt_cnt1_q;
        case (state_q)
            ST_IDLE: begin
                if (s0.tvalid || s1.tvalid) begin
                    state_d      = winner ? ST_GRANT1 : ST_GRANT0;
                    last_grant_d = winner;
                    beat_cnt_d   = '0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                // Grant is only released by an accepted tlast beat, never by tvalid dropping.
                if (accept) begin
                    beat_cnt_d = sat_inc(beat_cnt_q);
                    if (m.tlast) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_GRANT1) pkt_cnt1_d = pkt_cnt1_q + 1'b1;
                        else                      pkt_cnt0_d = pkt_cnt0_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
        end
    end

    assign busy     = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign grant_id = (state_q == ST_GRANT1);
    assign beat_cnt = beat_cnt_q;
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;

endmodule
